// File: rtl/regfile_dump_reader.sv
// Streams every register-file word through a valid/ready port, lowest index first.
// Define DUMP_CHECKSUM_EN to append one XOR checksum word after the last register.
module regfile_dump_reader #(
  parameter int ADDR_SIZE  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_SIZE-1:0]  RA,
  input  logic [DATA_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_SIZE-1:0]  dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_SIZE-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  state_t state, state_nxt;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
  logic                  csum_sent;  // the word in SEND is the checksum, not a register
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: state_nxt = SEND;
      SEND: begin
        if (dout_ready) begin
`ifdef DUMP_CHECKSUM_EN
          if (csum_sent)       state_nxt = FIN;
          else if (RA != LAST) state_nxt = READ;
          else                 state_nxt = SEND;
`else
          if (RA != LAST) state_nxt = READ;
          else            state_nxt = FIN;
`endif
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      RA         <= '0;
      dout       <= '0;
      dout_addr  <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      checksum   <= '0;
      csum_sent  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            RA   <= '0;
            busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
            csum_sent <= 1'b0;
`endif
          end
        end
        READ: begin
          dout       <= RD;
          dout_addr  <= RA;
          dout_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          dout_last  <= 1'b0;
          checksum   <= checksum ^ RD;
`else
          dout_last  <= (RA == LAST);
`endif
        end
        SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (RA != LAST) RA <= RA + ADDR_SIZE'(1);
`ifdef DUMP_CHECKSUM_EN
            // last register just left: present the checksum straight away
            if (!csum_sent && RA == LAST) begin
              dout       <= checksum;
              dout_addr  <= '0;
              dout_last  <= 1'b1;
              dout_valid <= 1'b1;
              csum_sent  <= 1'b1;
            end
`endif
          end
        end
        FIN: begin
          busy <= 1'b0;
          RA   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader against a word-list model.
module tb_regfile_dump_reader;
  localparam int AW = 5, DW = 32, N = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic CLK = 1'b0;
  logic rst = 1'b1, start = 1'b0, dout_ready = 1'b0;
  logic [AW-1:0] RA, dout_addr;
  logic [DW-1:0] RD, dout;
  logic dout_valid, dout_last, busy, done;
  logic [DW-1:0] rf [N];

  int n_cmp = 0, n_err = 0;

  typedef struct packed {logic [DW-1:0] d; logic [AW-1:0] a; logic l;} word_t;
  word_t cap[$], exp_q[$], held[$];
  logic  held_v[$];

  regfile_dump_reader #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .rst(rst), .start(start), .RA(RA), .RD(RD), .dout(dout),
    .dout_addr(dout_addr), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done));

  assign RD = rf[RA];
  always #5 CLK = ~CLK;

  // every accepted word, as the sink sees it
  always @(negedge CLK)
    if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1)
      cap.push_back({dout, dout_addr, dout_last});

  // expected stream: registers 0..N-1, then the XOR word when enabled
  function automatic void build_exp();
    logic [DW-1:0] x = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({rf[i], AW'(i), (CS == 0 && i == N-1)});
      x ^= rf[i];
    end
    if (CS == 1) exp_q.push_back({x, AW'(0), 1'b1});
  endfunction

  task automatic do_dump(input bit rnd, input bit restart10, input int stall_addr,
                         input bit start_on_fin, output int lat, output int c_done,
                         output int n_done, output logic busy_mid, output logic busy_after);
    int stall_left = 0, post = -1;
    bit stalled = 0;
    cap.delete(); held.delete(); held_v.delete();
    lat = -1; c_done = -1; n_done = 0; busy_mid = 1'b0; busy_after = 1'bx;
    @(posedge CLK); #1;
    start = 1'b1;
    dout_ready = rnd ? 1'($urandom % 2) : 1'b1;
    for (int c = 1; c < 4000; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (c == 1) busy_mid = busy;
      if (lat < 0 && dout_valid) lat = c;
      if (stall_left > 0) begin
        held.push_back({dout, dout_addr, dout_last});
        held_v.push_back(dout_valid);
        stall_left--;
      end
      if (stall_addr >= 0 && !stalled && dout_valid && dout_addr == AW'(stall_addr)) begin
        stalled = 1; stall_left = 5;
      end
      if (restart10 && dout_valid && dout_addr == AW'(10)) start = 1'b1;
      if (done) begin
        n_done++;
        if (c_done < 0) begin
          c_done = c; post = 0;
          if (start_on_fin) start = 1'b1;
        end
      end
      if (post >= 0) begin
        if (post == 3) begin busy_after = busy; break; end
        post++;
      end
      dout_ready = (stall_left > 0) ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
    end
    start = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dout_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (RA !== '0) begin n_err++; $display("FAIL reset_RA got %0d want 0", RA); end
    n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
    n_cmp++; if (dout_addr !== '0) begin n_err++; $display("FAIL reset_dout_addr got %0d want 0", dout_addr); end
    n_cmp++; if ({dout_valid, dout_last} !== 2'b00) begin n_err++; $display("FAIL reset_valid_last got %b want 00", {dout_valid, dout_last}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    rst = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_priority busy got %b want 0", busy); end
  endtask

  task automatic test_full_dump();
    int lat, c_done, n_done; logic bm, ba;
    for (int i = 0; i < N; i++) rf[i] = DW'(i) * 32'h0101_0101;
    do_dump(0, 0, -1, 0, lat, c_done, n_done, bm, ba);
    build_exp();
    n_cmp++; if (cap.size() !== exp_q.size()) begin n_err++; $display("FAIL full_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_err++; $display("FAIL full_word[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL full_latency got %0d want 2", lat); end
    n_cmp++; if (c_done !== 65 + CS) begin n_err++; $display("FAIL full_done_cycle got %0d want %0d", c_done, 65 + CS); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL full_done_pulses got %0d want 1", n_done); end
    n_cmp++; if (bm !== 1'b1) begin n_err++; $display("FAIL full_busy_during got %b want 1", bm); end
    n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL full_busy_after got %b want 0", ba); end
  endtask

  task automatic test_backpressure();
    int lat, c_done, n_done; logic bm, ba;
    for (int i = 0; i < N; i++) rf[i] = DW'(i) * 32'h0101_0101;
    do_dump(0, 0, 3, 0, lat, c_done, n_done, bm, ba);
    n_cmp++; if (held.size() !== 5) begin n_err++; $display("FAIL stall_samples got %0d want 5", held.size()); end
    for (int i = 0; i < held.size(); i++) begin
      n_cmp++;
      if (held_v[i] !== 1'b1 || held[i].d !== 32'h0303_0303 || held[i].a !== AW'(3)) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b d=%h a=%0d want v=1 d=03030303 a=3", i, held_v[i], held[i].d, held[i].a);
      end
    end
    build_exp();
    n_cmp++; if (cap.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_word[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_restart_ignored();
    int lat, c_done, n_done; logic bm, ba;
    for (int i = 1; i < N; i++) rf[i] = $urandom;
    rf[0] = '0;
    do_dump(0, 1, -1, 0, lat, c_done, n_done, bm, ba);
    build_exp();
    n_cmp++; if (cap.size() !== exp_q.size()) begin n_err++; $display("FAIL restart_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_err++; $display("FAIL restart_word[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL restart_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int lat, c_done, n_done; logic bm, ba;
    bit found = 0;
    for (int i = 0; i < N; i++) rf[i] = DW'(i) * 32'h0101_0101;
    @(posedge CLK); #1; start = 1'b1; dout_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1; start = 1'b0;
      if (dout_valid && dout_addr == AW'(17)) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL midrst_reach17 got 0 want 1"); end
    rst = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || RA !== '0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrst_state got v=%b busy=%b RA=%0d done=%b want 0/0/0/0", dout_valid, busy, RA, done);
    end
    rst = 1'b0;
    repeat (2) @(posedge CLK);
    do_dump(0, 0, -1, 0, lat, c_done, n_done, bm, ba);
    build_exp();
    n_cmp++; if (cap.size() !== exp_q.size()) begin n_err++; $display("FAIL midrst_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_word[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_checksum();
`ifdef DUMP_CHECKSUM_EN
    int lat, c_done, n_done; logic bm, ba;
    for (int i = 0; i < N; i++) rf[i] = DW'(i);
    do_dump(0, 0, -1, 0, lat, c_done, n_done, bm, ba);
    n_cmp++;
    if (cap.size() !== 33 || cap[32] !== {32'h0, AW'(0), 1'b1}) begin
      n_err++; $display("FAIL csum_zero got n=%0d last=%h want n=33 last=%h", cap.size(), cap[cap.size()-1], {32'h0, AW'(0), 1'b1});
    end
    rf[5] = 32'hFFFF_FFFF;
    do_dump(0, 0, -1, 0, lat, c_done, n_done, bm, ba);
    n_cmp++;
    if (cap.size() !== 33 || cap[32] !== {32'hFFFF_FFFA, AW'(0), 1'b1}) begin
      n_err++; $display("FAIL csum_fffa got n=%0d last=%h want n=33 last=%h", cap.size(), cap[cap.size()-1], {32'hFFFF_FFFA, AW'(0), 1'b1});
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, c_done, n_done; logic bm, ba;
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i < N; i++) rf[i] = $urandom;
      rf[0] = '0;
      // first run also pulses start during the done cycle; it must not launch a dump
      do_dump(1, 0, -1, (k == 0), lat, c_done, n_done, bm, ba);
      build_exp();
      n_cmp++; if (cap.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b%0d_count got %0d want %0d", k, cap.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
        n_cmp++; if (cap[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b%0d_word[%0d] got %h want %h", k, i, cap[i], exp_q[i]); end
      end
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL b2b%0d_latency got %0d want 2", k, lat); end
      n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL b2b%0d_done_pulses got %0d want 1", k, n_done); end
      n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL b2b%0d_busy_after got %b want 0", k, ba); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) rf[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_checksum();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 Parameter ADDR_SIZE, default 5, register address width; depth is 2**ADDR_SIZE.
REQ-002 Parameter DATA_WIDTH, default 32, register word width.
REQ-003 CLK  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle dump request.
REQ-006 RA  output  ADDR_SIZE  read address driven to the register file read port.
REQ-007 RD  input  DATA_WIDTH  combinational read data returned for RA; RA=0 returns 0.
REQ-008 dout  output  DATA_WIDTH  streamed word.
REQ-009 dout_addr  output  ADDR_SIZE  register index of dout.
REQ-010 dout_valid  output  1  dout/dout_addr/dout_last valid.
REQ-011 dout_ready  input  1  sink accepts word when high with dout_valid.
REQ-012 dout_last  output  1  marks final word of a dump.
REQ-013 busy  output  1  high from the cycle after accepted start until done.
REQ-014 done  output  1  one-cycle pulse after final word accepted.

Function
REQ-015 FSM states IDLE, READ, SEND, FIN; IDLE after reset.
REQ-016 IDLE: start=1 -> RA<=0, checksum<=0, busy<=1, state READ; start=0 -> stay.
REQ-017 READ (exactly one cycle): dout<=RD, dout_addr<=RA, dout_valid<=1, dout_last<=(RA==2**ADDR_SIZE-1 and no checksum word pending), state SEND.
REQ-018 SEND: dout_valid=1 and dout_ready=0 -> hold dout, dout_addr, dout_last unchanged; no state change.
REQ-019 SEND: dout_ready=1 -> word transferred; dout_valid<=0; if RA<2**ADDR_SIZE-1 then RA<=RA+1, state READ; else state FIN.
REQ-020 FIN: done=1 for exactly one cycle, busy<=0, RA<=0, state IDLE.
REQ-021 Latency: start at edge t -> first dout_valid high after edge t+2; with dout_ready held high one word per 2 cycles; full dump of 32 words = 64 cycles start-to-done pulse plus FIN.
REQ-022 RA does not wrap: the dump terminates at index 2**ADDR_SIZE-1; RA never increments past it.
REQ-023 start while busy is ignored; no restart, no queuing.
REQ-024 start in the same cycle as the FIN done pulse is ignored; new start accepted from IDLE only.
REQ-025 dout_ready while dout_valid=0 has no effect.
REQ-026 Register 0 dumped as RD returns it (value 0); no special-casing inside this block.
REQ-027 RA is a registered output; RD sampled only in READ.

Reset
REQ-028 rst=1 at any edge, including mid-dump: state IDLE, RA=0, dout=0, dout_addr=0, dout_valid=0, dout_last=0, busy=0, done=0, checksum=0.
REQ-029 rst has priority over start and dout_ready in the same cycle; an interrupted dump is abandoned, not resumed.

Configuration
REQ-030 Macro DUMP_CHECKSUM_EN defined: checksum accumulates XOR of every word captured in READ; after the register 2**ADDR_SIZE-1 word is accepted, one extra word dout=checksum, dout_addr=0, dout_last=1 is sent with the same SEND handshake, then FIN; dout_last is 0 on all register words.
REQ-031 Macro DUMP_CHECKSUM_EN undefined: no checksum register, no extra word; dout_last=1 on the register 2**ADDR_SIZE-1 word; dump length 2**ADDR_SIZE words.

Verification
REQ-032 Regfile model rf[i]=i*0x01010101 (rf[0]=0), dout_ready=1, start pulse -> 32 words, dout_addr 0..31 in order, dout = model values, dout_last only on addr 31, done pulse once, busy low after.
REQ-033 dout_ready low for 5 cycles while word addr 3 valid -> dout=0x03030303, dout_addr=3 held stable all 5 cycles, no word lost or duplicated.
REQ-034 start pulsed again at word addr 10 -> ignored; dump completes with exactly 32 words, single done pulse.
REQ-035 rst asserted while dout_addr=17 valid -> next cycle dout_valid=0, busy=0, RA=0; subsequent start begins again at addr 0.
REQ-036 DUMP_CHECKSUM_EN defined, rf[i]=i -> 33 words, final word dout=0x00000000 (XOR of 0..31), dout_addr=0, dout_last=1; set rf[5]=0xFFFFFFFF -> checksum 0xFFFFFFFA.
REQ-037 Random dout_ready backpressure (50%), 3 back-to-back dumps -> each 32 (or 33) words in order, start-to-first-valid exactly 2 cycles.
